tug_playfield: RTL
==================

TUG_PLAYFIELD -- requirements
Module: tug_playfield

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, meaning the number of cycles a round-win display is held before play resumes.
REQ-002 Port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, synchronous, active-high reset.
REQ-004 Port cpu_press, input, 1, computer press from the compButton stage; already synchronous to clk.
REQ-005 Port human_key, input, 1, raw human key, active-high, asynchronous to clk.
REQ-006 Port leds, output, 9, playfield lights; bit 0 is the computer end and bit 8 is the human end.
REQ-007 Port score_h, output, 3, human round wins.
REQ-008 Port score_c, output, 3, computer round wins.
REQ-009 Port match_over, output, 1, high once either score reaches 7.
REQ-010 Port hex_h, output, 7, active-low seven-segment code for score_h.
REQ-011 Port hex_c, output, 7, active-low seven-segment code for score_c.

Function
REQ-012 human_key SHALL pass through a 2-flop synchronizer; a human press event SHALL be asserted when the synchronized value is high and its previous value was low.
REQ-013 A cpu press event SHALL be asserted when cpu_press is high and its registered previous value was low, so a held level counts once.
REQ-014 Latency: a human_key rise sampled at edge k SHALL move the light at edge k+2.
REQ-015 Latency: a cpu_press rise sampled at edge k SHALL move the light at edge k.
REQ-016 The FSM SHALL have states PLAY, WIN_H, WIN_C and DONE.
REQ-017 In PLAY, pos (0..8) SHALL be shown one-hot on leds.
REQ-018 In PLAY, a human event alone SHALL increment pos, and a cpu event alone SHALL decrement pos.
REQ-019 In PLAY, simultaneous human and cpu events SHALL leave pos unchanged.
REQ-020 In PLAY, a human-only event at pos 8 SHALL cause the transition to WIN_H and increment score_h.
REQ-021 In PLAY, a cpu-only event at pos 0 SHALL cause the transition to WIN_C and increment score_c.
REQ-022 In WIN_H, leds SHALL be 9'h1F0; in WIN_C, leds SHALL be 9'h01F.
REQ-023 WIN_H and WIN_C SHALL ignore all press events and hold for exactly HOLD_CYCLES cycles.
REQ-024 On leaving WIN_H or WIN_C, pos SHALL be set to 4 and the FSM SHALL return to PLAY, or go to DONE if either score equals 7.
REQ-025 DONE SHALL be terminal until reset, with leds all on and match_over high; scores SHALL never exceed 7.
REQ-026 The hold counter SHALL be wide enough for HOLD_CYCLES and SHALL clear on every entry to a WIN state.

Reset
REQ-027 While reset is high at a clock edge, the block SHALL set state PLAY, pos 4 (leds 9'h010), scores 0, match_over 0, synchronizer and edge registers 0, and hold counter 0.
REQ-028 Reset asserted in any state, including mid-hold or DONE, SHALL take effect at that edge, and press events in the same cycle SHALL be discarded.

Configuration
REQ-029 With macro TUG_SCORE_HEX_EN defined, hex_h and hex_c SHALL show decimal digits 0..7 of the scores (0 = 7'b1000000).
REQ-030 With TUG_SCORE_HEX_EN undefined, hex_h and hex_c SHALL be constant 7'h7F (blank), and score_h and score_c SHALL still operate.

Structure
REQ-031 Package tug_pkg SHALL hold the state enum, the constants CENTER_POS=4, MAX_POS=8, WIN_SCORE=7, and the seven-segment digit table.
REQ-032 Sub-module press_edge (ports clk, reset, in, pulse) SHALL implement the edge detect and SHALL be instantiated for both press inputs.
REQ-033 The 2-flop synchronizer SHALL sit in tug_playfield ahead of the human press_edge instance.

Verification
REQ-034 Reset, then 4 separated human presses -> leds steps 9'h020, 9'h040, 9'h080, 9'h100, each 2 cycles after the key rise.
REQ-035 From pos 4, hold cpu_press high for 10 cycles -> exactly one step, to leds 9'h008.
REQ-036 Human and cpu events in the same PLAY cycle -> leds unchanged, scores unchanged.
REQ-037 From pos 0, a cpu press -> WIN_C, leds 9'h01F for 4 cycles, score_c 1, then leds 9'h010; presses during the hold are ignored.
REQ-038 Human wins 7 rounds -> score_h 7, match_over 1, leds 9'h1FF, further presses ignored; then reset -> all reset values.
REQ-039 With TUG_SCORE_HEX_EN defined and score_c 3 -> hex_c 7'b0110000; with it undefined -> hex_c 7'h7F.

Source files
------------

// File: rtl/tug_pkg.sv
// -----------------------------------------------------------------------------
// tug_pkg
// Shared definitions for the tug-of-war playfield:
//   - tug_state_e : playfield FSM states (PLAY, WIN_H, WIN_C, DONE)
//   - CENTER_POS, MAX_POS, WIN_SCORE : game geometry and match length
//   - SEG_BLANK, seg_digit() : active-low seven-segment digit table (gfedcba)
// -----------------------------------------------------------------------------
package tug_pkg;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_WIN_H = 2'd1,
      ST_WIN_C = 2'd2,
      ST_DONE  = 2'd3
   } tug_state_e;

   localparam logic [3:0] CENTER_POS = 4'd4;
   localparam logic [3:0] MAX_POS    = 4'd8;
   localparam logic [2:0] WIN_SCORE  = 3'd7;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   // Active-low segments, bit order gfedcba; only digits 0..7 are reachable.
   function automatic logic [6:0] seg_digit(input logic [2:0] d);
      logic [6:0] seg;
      case (d)
         3'd0:    seg = 7'b1000000;
         3'd1:    seg = 7'b1111001;
         3'd2:    seg = 7'b0100100;
         3'd3:    seg = 7'b0110000;
         3'd4:    seg = 7'b0011001;
         3'd5:    seg = 7'b0010010;
         3'd6:    seg = 7'b0000010;
         default: seg = 7'b1111000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/press_edge.sv
// -----------------------------------------------------------------------------
// press_edge
// Rising-edge detector: pulse is high for the cycle in which 'in' is high and
// its registered previous value is low, so a held level produces one pulse.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset (clears the history register)
//   in    - level input, already synchronous to clk
//   pulse - combinational one-cycle rise indication
// -----------------------------------------------------------------------------
module press_edge (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b0;
      end else begin
         prev <= in;
      end
   end

   // Combinational so the caller can act on the same edge that samples 'in'.
   assign pulse = in & ~prev;

endmodule

// File: rtl/tug_playfield.sv
// -----------------------------------------------------------------------------
// tug_playfield
// Tug-of-war game core. A light travels along a 9-LED field; human presses
// push it toward bit 8, computer presses toward bit 0. Pushing off an end
// wins the round, shows a win pattern for HOLD_CYCLES cycles, and recentres.
// First side to 7 round wins ends the match (terminal until reset).
// Parameters:
//   HOLD_CYCLES - cycles the round-win pattern is shown
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   cpu_press  - computer press level, synchronous to clk
//   human_key  - human key level, asynchronous, active-high
//   leds[8:0]  - playfield (bit 0 computer end, bit 8 human end)
//   score_h    - human round wins
//   score_c    - computer round wins
//   match_over - high once either score is 7
//   hex_h/hex_c- active-low seven-segment score digits
// Build option:
//   TUG_SCORE_HEX_EN - when defined, hex_h/hex_c decode the scores;
//                      otherwise they are held blank (7'h7F).
// -----------------------------------------------------------------------------
module tug_playfield
   import tug_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_press,
   input  logic       human_key,
   output logic [8:0] leds,
   output logic [2:0] score_h,
   output logic [2:0] score_c,
   output logic       match_over,
   output logic [6:0] hex_h,
   output logic [6:0] hex_c
);

   // Counter counts 0..HOLD_CYCLES-1 but is sized to hold HOLD_CYCLES itself.
   localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   tug_state_e        state;
   logic [3:0]        pos;
   logic [HOLD_W-1:0] hold_cnt;

   logic sync_1;
   logic sync_2;
   logic ev_h;
   logic ev_c;

   // Two-flop synchronizer for the asynchronous human key.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= human_key;
         sync_2 <= sync_1;
      end
   end

   press_edge u_edge_h (
      .clk   (clk),
      .reset (reset),
      .in    (sync_2),
      .pulse (ev_h)
   );

   press_edge u_edge_c (
      .clk   (clk),
      .reset (reset),
      .in    (cpu_press),
      .pulse (ev_c)
   );

   // Playfield FSM. Reset has priority, so any press in a reset cycle is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_PLAY;
         pos      <= CENTER_POS;
         score_h  <= 3'd0;
         score_c  <= 3'd0;
         hold_cnt <= '0;
      end else begin
         case (state)
            ST_PLAY: begin
               // Simultaneous presses cancel out and fall through both arms.
               if (ev_h && !ev_c) begin
                  if (pos == MAX_POS) begin
                     state    <= ST_WIN_H;
                     hold_cnt <= '0;
                     if (score_h != WIN_SCORE) score_h <= score_h + 3'd1;
                  end else begin
                     pos <= pos + 4'd1;
                  end
               end else if (ev_c && !ev_h) begin
                  if (pos == 4'd0) begin
                     state    <= ST_WIN_C;
                     hold_cnt <= '0;
                     if (score_c != WIN_SCORE) score_c <= score_c + 3'd1;
                  end else begin
                     pos <= pos - 4'd1;
                  end
               end
            end
            ST_WIN_H, ST_WIN_C: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= '0;
                  pos      <= CENTER_POS;
                  state    <= ((score_h == WIN_SCORE) || (score_c == WIN_SCORE))
                              ? ST_DONE : ST_PLAY;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_ONE;
               end
            end
            default: begin
               state <= ST_DONE;
            end
         endcase
      end
   end

   always_comb begin
      leds = 9'h000;
      case (state)
         ST_PLAY:  leds = 9'b1 << pos;
         ST_WIN_H: leds = 9'h1F0;
         ST_WIN_C: leds = 9'h01F;
         default:  leds = 9'h1FF;
      endcase
   end

   assign match_over = (score_h == WIN_SCORE) || (score_c == WIN_SCORE);

`ifdef TUG_SCORE_HEX_EN
   assign hex_h = seg_digit(score_h);
   assign hex_c = seg_digit(score_c);
`else
   assign hex_h = SEG_BLANK;
   assign hex_c = SEG_BLANK;
`endif

endmodule
